// File: rtl/mult8_nibble_seq_pkg.sv
// Shared definitions for the nibble-sequenced 8x8 multiplier: FSM state
// encoding, per-step accumulate shifts and the nibble width.
package mult8_nibble_seq_pkg;

    localparam int NIB_W = 4;

    // Left shift applied to each nibble product before it is accumulated.
    localparam int SH0 = 0;   // aL * bL
    localparam int SH1 = 4;   // aH * bL
    localparam int SH2 = 4;   // aL * bH
    localparam int SH3 = 8;   // aH * bH

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Map a step index onto its accumulate shift amount.
    function automatic logic [3:0] step_shift(input logic [1:0] step);
        case (step)
            2'd0:    step_shift = 4'(SH0);
            2'd1:    step_shift = 4'(SH1);
            2'd2:    step_shift = 4'(SH2);
            default: step_shift = 4'(SH3);
        endcase
    endfunction

endpackage

// File: rtl/mult8_nibble_seq_if.sv
// Operand/result handshake bundle between a requesting datapath (master)
// and the nibble-sequenced multiplier (slave).
interface mult8_nibble_seq_if;
    import mult8_nibble_seq_pkg::*;

    logic [2*NIB_W-1:0] a;
    logic [2*NIB_W-1:0] b;
    logic               in_valid;
    logic               in_ready;
    logic [4*NIB_W-1:0] prod;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    modport master (
        output a,
        output b,
        output in_valid,
        input  in_ready,
        input  prod,
        input  out_valid,
        output out_ready,
        input  busy
    );

    modport slave (
        input  a,
        input  b,
        input  in_valid,
        output in_ready,
        output prod,
        output out_valid,
        input  out_ready,
        output busy
    );

endinterface

// File: rtl/mult8_nibble_seq_mult4.sv
// Combinational unsigned 4x4 array multiplier: rows of AND partial products
// are folded into a running sum with ripple-carry full-adder rows.
module top_4BIT_ARRAY_MULTIPLIER (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    // Array reduction: each row adds the next partial product to the upper
    // bits of the previous row; the row LSB drops out as a product bit.
    always_comb begin
        logic [4:0] row;
        logic [3:0] sum;
        logic       carry;
        logic       x;
        logic       y;
        // NOTE: every variable gets a value before any branch or loop so the
        // block stays purely combinational and no latch is inferred.
        row   = {1'b0, a & {4{b[0]}}};
        sum   = '0;
        carry = 1'b0;
        x     = 1'b0;
        y     = 1'b0;
        p     = '0;
        p[0]  = row[0];
        for (int i = 1; i < 4; i++) begin
            carry = 1'b0;
            sum   = '0;
            for (int j = 0; j < 4; j++) begin
                x      = row[j+1];
                y      = a[j] & b[i];
                sum[j] = x ^ y ^ carry;
                carry  = (x & y) | (carry & (x ^ y));
            end
            row  = {carry, sum};
            p[i] = row[0];
        end
        p[7:4] = row[4:1];
    end

endmodule

// File: rtl/mult8_nibble_seq.sv
// Unsigned 8x8 -> 16 multiplier that reuses one 4x4 array multiplier over
// four nibble-product steps, with valid/ready handshakes on both sides.
module mult8_nibble_seq
    import mult8_nibble_seq_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b0
) (
    input logic               clk,
    input logic               rst,
    mult8_nibble_seq_if.slave bus
);

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         step_q;
    logic [1:0]         step_d;
    logic [2*NIB_W-1:0] a_q;
    logic [2*NIB_W-1:0] a_d;
    logic [2*NIB_W-1:0] b_q;
    logic [2*NIB_W-1:0] b_d;
    logic [4*NIB_W-1:0] acc_q;
    logic [4*NIB_W-1:0] acc_d;

    logic [NIB_W-1:0]   mul_a;
    logic [NIB_W-1:0]   mul_b;
    logic [2*NIB_W-1:0] pp;
    logic [4*NIB_W-1:0] addend;
    logic               zero_op;

    // Nibble select: feed the shared multiplier for the current step, and
    // hold its inputs at zero outside MUL so it does not toggle.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state_q == MUL) begin
            case (step_q)
                2'd0: begin
                    mul_a = a_q[NIB_W-1:0];
                    mul_b = b_q[NIB_W-1:0];
                end
                2'd1: begin
                    mul_a = a_q[2*NIB_W-1:NIB_W];
                    mul_b = b_q[NIB_W-1:0];
                end
                2'd2: begin
                    mul_a = a_q[NIB_W-1:0];
                    mul_b = b_q[2*NIB_W-1:NIB_W];
                end
                default: begin
                    mul_a = a_q[2*NIB_W-1:NIB_W];
                    mul_b = b_q[2*NIB_W-1:NIB_W];
                end
            endcase
        end
    end

    top_4BIT_ARRAY_MULTIPLIER u_mult4 (
        .a (mul_a),
        .b (mul_b),
        .p (pp)
    );

    // Nibble product placed at its weight; cannot overflow the 16-bit sum
    // because the full product never exceeds 0xFE01.
    assign addend  = {{(2*NIB_W){1'b0}}, pp} << step_shift(step_q);
    assign zero_op = ZERO_SKIP && ((bus.a == '0) || (bus.b == '0));

    // Next-state and datapath update for IDLE/MUL/DONE.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_d   = '0;
                    step_d  = 2'd0;
                    state_d = zero_op ? DONE : MUL;
                end
            end
            MUL: begin
                acc_d  = acc_q + addend;
                step_d = step_q + 2'd1;   // wraps to 0 after step 3
                if (step_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = 2'd0;
            end
        endcase
    end

    // State, operand and accumulator registers; reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.prod      = acc_q;

    // The result must not move while the consumer is stalling it.
    a_prod_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.prod)));

    // The step counter only advances inside MUL.
    a_step_idle: assert property (@(posedge clk) disable iff (rst)
        (state_q != MUL) |-> (step_q == 2'd0));

    // Accepting and working are mutually exclusive.
    a_ready_busy: assert property (@(posedge clk) disable iff (rst)
        !(bus.in_ready && bus.busy));

endmodule

// File: tb/tb_mult8_nibble_seq.sv
// Self-checking bench: two instances (ZERO_SKIP=0 and ZERO_SKIP=1) share
// one stimulus stream; a timeline model predicts handshakes and products.
module tb_mult8_nibble_seq;

    logic clk;
    logic rst;
    bit   chk_en = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [15:0] out_log [$];

    // Model state per instance: idle flag, cycles left before the result
    // appears, and the product a*b computed arithmetically.
    logic        m_idle [2];
    int          m_wait [2];
    logic [15:0] m_res  [2];

    mult8_nibble_seq_if bus0 ();
    mult8_nibble_seq_if bus1 ();

    mult8_nibble_seq #(.ZERO_SKIP(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    mult8_nibble_seq #(.ZERO_SKIP(1'b1)) dut_zs (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every completed output handshake of the ZERO_SKIP=0 instance.
    always @(posedge clk) begin
        if (!rst && bus0.out_valid && bus0.out_ready) out_log.push_back(bus0.prod);
    end

    // Behavioural model: accept in IDLE, result visible 5 cycles later
    // (1 cycle for a zero operand on the skipping instance), leave on
    // out_ready.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_idle[k] <= 1'b1;
                m_wait[k] <= 0;
                m_res[k]  <= 16'h0;
            end else if (m_idle[k]) begin
                if (bus0.in_valid) begin
                    m_idle[k] <= 1'b0;
                    m_res[k]  <= 16'(bus0.a) * 16'(bus0.b);
                    m_wait[k] <= (k == 1 && (bus0.a == 8'h0 || bus0.b == 8'h0)) ? 0 : 4;
                end
            end else if (m_wait[k] != 0) begin
                m_wait[k] <= m_wait[k] - 1;
            end else if (bus0.out_ready) begin
                m_idle[k] <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_one(input int k, input logic rdy, input logic vld,
                               input logic bsy, input logic [15:0] prd);
        logic exp_valid;
        exp_valid = !m_idle[k] && (m_wait[k] == 0);
        check($sformatf("cmp%0d_in_ready", k), rdy, m_idle[k]);
        check($sformatf("cmp%0d_busy", k), bsy, !m_idle[k]);
        check($sformatf("cmp%0d_out_valid", k), vld, exp_valid);
        if (rst || exp_valid) check($sformatf("cmp%0d_prod", k), prd, rst ? 16'h0 : m_res[k]);
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            compare_one(0, bus0.in_ready, bus0.out_valid, bus0.busy, bus0.prod);
            compare_one(1, bus1.in_ready, bus1.out_valid, bus1.busy, bus1.prod);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] xa, input logic [7:0] xb, input logic v);
        bus0.a = xa; bus0.b = xb; bus0.in_valid = v;
        bus1.a = xa; bus1.b = xb; bus1.in_valid = v;
    endtask

    task automatic set_ready(input logic r);
        bus0.out_ready = r;
        bus1.out_ready = r;
    endtask

    // Wait (bounded) until the instance under test shows in_ready while
    // in_valid is up; n is the accept cycle. Returns in cycle n+1.
    task automatic accept_wait(output int n);
        n = -100;
        for (int i = 0; i < 20; i++) begin
            if (bus0.in_ready) begin
                n = cyc;
                tick();
                return;
            end
            tick();
        end
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] xa, input logic [7:0] xb, output int n);
        drive(xa, xb, 1'b1);
        accept_wait(n);
        drive(xa, xb, 1'b0);
    endtask

    task automatic wait_out(input int k, output int w);
        w = -100;
        for (int i = 0; i < 30; i++) begin
            if ((k == 0) ? bus0.out_valid : bus1.out_valid) begin
                w = cyc;
                return;
            end
            tick();
        end
        check($sformatf("out_timeout%0d", k), 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int n2;
        int w;
        int w1;

        rst = 1'b1;
        drive(8'h00, 8'h00, 1'b0);
        set_ready(1'b1);
        tick();
        tick();
        check("reset_in_ready", bus0.in_ready, 1'b1);
        check("reset_out_valid", bus0.out_valid, 1'b0);
        check("reset_busy", bus0.busy, 1'b0);
        check("reset_prod", bus0.prod, 16'h0000);
        check("reset_zs_in_ready", bus1.in_ready, 1'b1);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // 0x12 * 0x34 = 936
        send(8'h12, 8'h34, n);
        check("t1_in_ready_busy", bus0.in_ready, 1'b0);
        wait_out(0, w);
        check("t1_latency", w - n, 5);
        check("t1_prod", bus0.prod, 16'h03A8);
        check("model_pin_12x34", m_res[0], 16'h03A8);
        tick();
        check("t1_idle_after", bus0.in_ready, 1'b1);

        // Extremes and corner nibbles
        send(8'hFF, 8'hFF, n);
        wait_out(0, w);
        check("ff_prod", bus0.prod, 16'hFE01);
        check("model_pin_ffxff", m_res[0], 16'hFE01);
        tick();
        send(8'hF0, 8'h0F, n);
        wait_out(0, w);
        check("f0x0f_prod", bus0.prod, 16'h0E10);
        tick();

        // Backpressure for 3 cycles
        set_ready(1'b0);
        send(8'h0A, 8'h0B, n);
        wait_out(0, w);
        check("bp_latency", w - n, 5);
        check("bp_prod", bus0.prod, 16'h006E);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", bus0.out_valid, 1'b1);
            check("bp_hold_prod", bus0.prod, 16'h006E);
        end
        set_ready(1'b1);
        tick();
        check("bp_idle_in_ready", bus0.in_ready, 1'b1);
        check("bp_idle_busy", bus0.busy, 1'b0);

        // Zero operand: skipping instance finishes at N+1, other at N+5
        send(8'h00, 8'h5A, n);
        wait_out(1, w1);
        check("zs1_latency", w1 - n, 1);
        check("zs1_prod", bus1.prod, 16'h0000);
        wait_out(0, w);
        check("zs0_latency", w - n, 5);
        check("zs0_prod", bus0.prod, 16'h0000);
        tick();

        // Reset in the middle of 0x99 * 0x77
        send(8'h99, 8'h77, n);
        tick();
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", bus0.busy, 1'b0);
        check("rst_mid_in_ready", bus0.in_ready, 1'b1);
        check("rst_mid_out_valid", bus0.out_valid, 1'b0);
        check("rst_mid_prod", bus0.prod, 16'h0000);
        check("rst_mid_zs_busy", bus1.busy, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rst_no_output", bus0.out_valid, 1'b0);
        end
        send(8'h03, 8'h05, n);
        wait_out(0, w);
        check("post_rst_latency", w - n, 5);
        check("post_rst_prod", bus0.prod, 16'h000F);
        tick();

        // Back-to-back with in_valid held high
        drive(8'h10, 8'h10, 1'b1);
        accept_wait(n);
        drive(8'h02, 8'h80, 1'b1);
        accept_wait(n2);
        drive(8'h02, 8'h80, 1'b0);
        check("b2b_spacing", n2 - n, 6);
        wait_out(0, w);
        check("b2b_second_prod", bus0.prod, 16'h0100);
        tick();
        tick();

        check("log_size", out_log.size(), 8);
        if (out_log.size() == 8) begin
            check("log_3a8", out_log[0], 16'h03A8);
            check("log_no_residue", out_log[5], 16'h000F);
            check("log_b2b_first", out_log[6], 16'h0100);
            check("log_b2b_second", out_log[7], 16'h0100);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
